// File: rtl/mult_issue_if.sv
// Handshake and operand/result bus between the multiply issue controller and its surroundings.
// master: the controller side; slave: the producer/multiplier/consumer side.
interface mult_issue_if #(
    parameter int unsigned NUM_BITS = 7
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_BITS-1:0]     in_multiplier;
    logic [NUM_BITS-1:0]     in_multiplicand;
    logic                    in_multiplier_t;
    logic                    in_multiplicand_t;
    logic                    start;
    logic                    start_t;
    logic [NUM_BITS-1:0]     multiplier;
    logic [NUM_BITS-1:0]     multiplicand;
    logic                    multiplier_t;
    logic                    multiplicand_t;
    logic [2*NUM_BITS-1:0]   product;
    logic                    out_valid;
    logic                    out_ready;
    logic [2*NUM_BITS-1:0]   out_product;
    logic                    out_taint;

    modport master (
        input  in_valid, in_multiplier, in_multiplicand, in_multiplier_t, in_multiplicand_t,
        input  product, out_ready,
        output in_ready, start, start_t, multiplier, multiplicand, multiplier_t, multiplicand_t,
        output out_valid, out_product, out_taint
    );

    modport slave (
        output in_valid, in_multiplier, in_multiplicand, in_multiplier_t, in_multiplicand_t,
        output product, out_ready,
        input  in_ready, start, start_t, multiplier, multiplicand, multiplier_t, multiplicand_t,
        input  out_valid, out_product, out_taint
    );
endinterface

// File: rtl/mult_issue_ctrl.sv
// Queues operand pairs and issues them one at a time to a fixed-latency sequential multiplier,
// capturing each product (with its taint) and holding it until the consumer accepts.
module mult_issue_ctrl #(
    parameter int unsigned NUM_BITS    = 7,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned MUL_LATENCY = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    mult_issue_if.master           bus,
    output logic [$clog2(DEPTH):0] fifo_count_o
);
    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CountW = PtrW + 1;
    localparam int unsigned CntW   = $clog2(MUL_LATENCY + 1);

    typedef struct packed {
        logic [NUM_BITS-1:0] mplier;
        logic [NUM_BITS-1:0] mcand;
        logic                mplier_t;
        logic                mcand_t;
    } entry_t;

    typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

    state_e              state_q, state_d;
    entry_t              mem_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0]   count_q, count_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    entry_t              op_q, op_d;
    logic                out_valid_q, out_valid_d;
    logic [2*NUM_BITS-1:0] out_product_q, out_product_d;
    logic                out_taint_q, out_taint_d;
    logic                full, push, pop;
    entry_t              in_entry;

    assign full     = (count_q == CountW'(DEPTH));
    assign push     = bus.in_valid && !full;
    assign in_entry = '{mplier:   bus.in_multiplier,
                        mcand:    bus.in_multiplicand,
                        mplier_t: bus.in_multiplier_t,
                        mcand_t:  bus.in_multiplicand_t};

    // Issue FSM: at most one operation in flight, operands latched at the pop.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        out_valid_d   = out_valid_q;
        out_product_d = out_product_q;
        out_taint_d   = out_taint_q;
        pop           = 1'b0;
        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    op_d    = mem_q[rd_ptr_q];
                    state_d = StStart;
                end
            end
            StStart: begin
                cnt_d   = CntW'(MUL_LATENCY - 1);
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    out_product_d = bus.product;
                    out_taint_d   = op_q.mplier_t | op_q.mcand_t;
                    out_valid_d   = 1'b1;
                    state_d       = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CountW'(1);
            2'b01:   count_d = count_q - CountW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cnt_q         <= '0;
            op_q          <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            out_taint_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
            out_taint_q   <= out_taint_d;
        end
    end

    assign bus.in_ready       = !full;
    assign bus.start          = (state_q == StStart);
    assign bus.start_t        = 1'b0;
    assign bus.multiplier     = op_q.mplier;
    assign bus.multiplicand   = op_q.mcand;
    assign bus.multiplier_t   = op_q.mplier_t;
    assign bus.multiplicand_t = op_q.mcand_t;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_product    = out_product_q;
    assign bus.out_taint      = out_taint_q;
    assign fifo_count_o       = count_q;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl: table of single-issue vectors plus hand-written
// sequences for queueing, backpressure, same-edge push/pop and reset abort.
module tb_mult_issue_ctrl;
    localparam int NB  = 7;
    localparam int DP  = 4;
    localparam int LAT = 16;

    typedef struct {
        logic [NB-1:0]   a;
        logic [NB-1:0]   b;
        logic            at;
        logic            bt;
        logic [2*NB-1:0] prod;
        logic            taint;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [$clog2(DP):0] fifo_count;
    logic [2*NB-1:0] mul_prod = '0;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int starts = 0;
    int start_t_bad = 0;
    int fifo_max = 0;

    mult_issue_if #(.NUM_BITS(NB)) bus ();

    mult_issue_ctrl #(.NUM_BITS(NB), .DEPTH(DP), .MUL_LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .fifo_count_o (fifo_count)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: latches the product of the issued operands on the start edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.start) begin
            mul_prod <= (2*NB)'(bus.multiplier) * (2*NB)'(bus.multiplicand);
            starts   <= starts + 1;
        end
    end
    assign bus.product = mul_prod;

    always @(negedge clk) begin
        if (bus.start_t !== 1'b0) start_t_bad <= start_t_bad + 1;
        if (int'(fifo_count) > fifo_max) fifo_max <= int'(fifo_count);
    end

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic at,
                        input logic bt, output int edge_cyc);
        bus.in_valid          = 1'b1;
        bus.in_multiplier     = a;
        bus.in_multiplicand   = b;
        bus.in_multiplier_t   = at;
        bus.in_multiplicand_t = bt;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        edge_cyc     = cyc;
    endtask

    task automatic wait_valid(input int max, output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    vec_t vecs [5];
    logic [2*NB-1:0] exp41 [3];
    logic [2*NB-1:0] exp42 [4];
    logic [2*NB-1:0] exp45 [3];

    initial begin
        int e, at, s0;
        bit ok;

        vecs[0] = '{a: 7'd15,  b: 7'd15,  at: 1'b0, bt: 1'b0, prod: 14'd225,   taint: 1'b0};
        vecs[1] = '{a: 7'd1,   b: 7'd2,   at: 1'b1, bt: 1'b0, prod: 14'd2,     taint: 1'b1};
        vecs[2] = '{a: 7'd127, b: 7'd127, at: 1'b0, bt: 1'b1, prod: 14'd16129, taint: 1'b1};
        vecs[3] = '{a: 7'd0,   b: 7'd12,  at: 1'b1, bt: 1'b1, prod: 14'd0,     taint: 1'b1};
        vecs[4] = '{a: 7'd92,  b: 7'd75,  at: 1'b0, bt: 1'b0, prod: 14'd6900,  taint: 1'b0};
        exp41[0] = 14'd6900; exp41[1] = 14'd3276; exp41[2] = 14'd0;
        exp42[0] = 14'd20; exp42[1] = 14'd42; exp42[2] = 14'd72; exp42[3] = 14'd110;
        exp45[0] = 14'd30; exp45[1] = 14'd56; exp45[2] = 14'd90;

        bus.in_valid = 1'b0;
        bus.in_multiplier = '0;
        bus.in_multiplicand = '0;
        bus.in_multiplier_t = 1'b0;
        bus.in_multiplicand_t = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_start", bus.start, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_product", bus.out_product, 0);
        check("rst_multiplier", bus.multiplier, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);

        // Single operations, one in flight, out_ready high
        for (int i = 0; i < 5; i++) begin
            s0 = starts;
            push(vecs[i].a, vecs[i].b, vecs[i].at, vecs[i].bt, e);
            wait_valid(60, at, ok);
            check($sformatf("vec%0d_valid", i), ok, 1);
            check($sformatf("vec%0d_latency", i), at - e, LAT + 2);
            check($sformatf("vec%0d_product", i), bus.out_product, vecs[i].prod);
            check($sformatf("vec%0d_taint", i), bus.out_taint, vecs[i].taint);
            @(negedge clk);
            check($sformatf("vec%0d_valid_drop", i), bus.out_valid, 0);
            check($sformatf("vec%0d_starts", i), starts - s0, 1);
        end

        // Three back-to-back pushes come out in order
        fifo_max = 0;
        s0 = starts;
        push(7'd92, 7'd75, 1'b0, 1'b0, e);
        push(7'd42, 7'd78, 1'b0, 1'b0, e);
        push(7'd0,  7'd12, 1'b0, 1'b0, e);
        for (int i = 0; i < 3; i++) begin
            wait_valid(60, at, ok);
            check($sformatf("b2b%0d_valid", i), ok, 1);
            check($sformatf("b2b%0d_product", i), bus.out_product, exp41[i]);
        end
        @(negedge clk);
        check("b2b_starts", starts - s0, 3);
        check("b2b_fifo_peak_ge2", fifo_max >= 2, 1);

        // Same-edge push and pop at fifo_count 2
        bus.out_ready = 1'b0;
        push(7'd3, 7'd4, 1'b0, 1'b0, e);
        push(7'd5, 7'd6, 1'b0, 1'b0, e);
        push(7'd7, 7'd8, 1'b0, 1'b0, e);
        wait_valid(60, at, ok);
        check("pp_first_valid", ok, 1);
        check("pp_first_product", bus.out_product, 12);
        check("pp_count_before", fifo_count, 2);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        push(7'd9, 7'd10, 1'b0, 1'b0, e);
        check("pp_count_after", fifo_count, 2);
        for (int i = 0; i < 3; i++) begin
            wait_valid(60, at, ok);
            check($sformatf("pp%0d_valid", i), ok, 1);
            check($sformatf("pp%0d_product", i), bus.out_product, exp45[i]);
        end
        @(negedge clk);

        // Backpressure: one result held, queue fills to DEPTH and refuses the fifth pair
        bus.out_ready = 1'b0;
        push(7'd2, 7'd3, 1'b0, 1'b0, e);
        wait_valid(60, at, ok);
        check("bp_first_valid", ok, 1);
        s0 = starts;
        for (int j = 0; j < 5; j++) begin
            if (j == 4) begin
                check("bp_count_full", fifo_count, 4);
                check("bp_in_ready_low", bus.in_ready, 0);
            end
            push(7'(4 + 2*j), 7'(5 + 2*j), 1'b0, 1'b0, e);
        end
        check("bp_count_hold", fifo_count, 4);
        repeat (LAT + 4) @(negedge clk);
        check("bp_valid_held", bus.out_valid, 1);
        check("bp_product_held", bus.out_product, 6);
        check("bp_no_start", starts - s0, 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid(60, at, ok);
            check($sformatf("bp%0d_valid", i), ok, 1);
            check($sformatf("bp%0d_product", i), bus.out_product, exp42[i]);
        end
        wait_valid(LAT + 8, at, ok);
        check("bp_fifth_dropped", ok, 0);
        check("bp_count_empty", fifo_count, 0);

        // Reset mid-WAIT discards the operation and the queued entry
        push(7'd0, 7'd0, 1'b0, 1'b0, e);
        push(7'd3, 7'd3, 1'b0, 1'b0, e);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rstw_start", bus.start, 0);
        check("rstw_out_valid", bus.out_valid, 0);
        check("rstw_fifo_count", fifo_count, 0);
        check("rstw_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        wait_valid(LAT + 8, at, ok);
        check("rstw_no_result", ok, 0);
        push(7'd1, 7'd2, 1'b0, 1'b0, e);
        wait_valid(60, at, ok);
        check("rstw_after_valid", ok, 1);
        check("rstw_after_latency", at - e, LAT + 2);
        check("rstw_after_product", bus.out_product, 2);
        @(negedge clk);

        // Reset during START drops the pulse and operands immediately
        push(7'd5, 7'd7, 1'b1, 1'b0, e);
        @(posedge clk);
        #1;
        check("rsts_start_high", bus.start, 1);
        check("rsts_multiplier", bus.multiplier, 5);
        check("rsts_mult_t", bus.multiplier_t, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rsts_start_low", bus.start, 0);
        check("rsts_multiplier_clr", bus.multiplier, 0);
        check("rsts_multiplicand_clr", bus.multiplicand, 0);
        check("rsts_mult_t_clr", bus.multiplier_t, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_valid(LAT + 8, at, ok);
        check("rsts_no_result", ok, 0);

        check("start_t_never_set", start_t_bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
